// File: rtl/mau_pkg.sv
// Shared types and constants for the multiply-accumulate unit.
package mau_pkg;

  localparam int MANT_W  = 18;
  localparam int EXP_W   = 5;
  localparam int EXP_MAX = 31;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mau_state_e;

  // Sign-magnitude float as produced by the multiplier stage.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MANT_W-1:0] mantissa;
  } mau_fp_t;

  // A zero exponent or a zero mantissa both encode the value zero.
  function automatic logic mau_is_zero(input mau_fp_t v);
    return (v.exponent == '0) || (v.mantissa == '0);
  endfunction

endpackage

// File: rtl/mau_lzc.sv
// Leading-zero counter over the 19-bit pre-normalisation sum.
module mau_lzc (
  input  logic [18:0] din,
  output logic [4:0]  count
);

  // Highest set bit wins; an all-zero input reports 19.
  always_comb begin
    count = 5'd19;
    for (int i = 0; i < 19; i++) begin
      if (din[i]) count = 5'(18 - i);
    end
  end

endmodule

// File: rtl/mau_accumulator.sv
// Sign-magnitude floating-point dot-product accumulator: align/add, then normalise.
module mau_accumulator
  import mau_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [MANT_W-1:0]     in_mantissa,
  input  logic [EXP_W-1:0]      in_exponent,
  input  logic                  in_sign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_W-1:0]     out_mantissa,
  output logic [EXP_W-1:0]      out_exponent,
  output logic                  out_sign,
  output logic [CNT_W-1:0]      out_count
);

  mau_state_e        state, state_d;
  logic              armed;
  mau_fp_t           acc;
  logic [CNT_W-1:0]  count;
  mau_fp_t           prod_p0;
  logic              last_p0;
  logic [MANT_W:0]   sum_mant_p1;
  logic [EXP_W-1:0]  sum_exp_p1;
  logic              sum_sign_p1;

  logic              accept;
  logic [MANT_W:0]   add_mant;
  logic [EXP_W-1:0]  add_exp;
  logic              add_sign;
  mau_fp_t           norm;
  logic [4:0]        lz;

  assign in_ready     = armed && (state == ST_IDLE);
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state == ST_DONE);
  assign out_mantissa = acc.mantissa;
  assign out_exponent = acc.exponent;
  assign out_sign     = acc.sign;
  assign out_count    = count;

  // Next-state logic for the IDLE -> ADD -> NORM -> (IDLE | DONE) sequence.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (accept)    state_d = ST_ADD;
      ST_ADD:                 state_d = ST_NORM;
      ST_NORM:                state_d = last_p0 ? ST_DONE : ST_IDLE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Align the smaller operand and add or subtract magnitudes.
  always_comb begin
    logic [EXP_W-1:0]  diff;
    logic [MANT_W-1:0] a_al, b_al;
    add_mant = {1'b0, acc.mantissa};
    add_exp  = acc.exponent;
    add_sign = acc.sign;
    diff     = '0;
    a_al     = '0;
    b_al     = '0;
    if (mau_is_zero(prod_p0)) begin
      // Zero product leaves the accumulator as it is.
      if (mau_is_zero(acc)) add_mant = '0;
    end else if (mau_is_zero(acc)) begin
      add_mant = {1'b0, prod_p0.mantissa};
      add_exp  = prod_p0.exponent;
      add_sign = prod_p0.sign;
    end else begin
      if (acc.exponent >= prod_p0.exponent) begin
        diff    = acc.exponent - prod_p0.exponent;
        add_exp = acc.exponent;
        a_al    = acc.mantissa;
        b_al    = (diff >= 5'd18) ? '0 : (prod_p0.mantissa >> diff);
      end else begin
        diff    = prod_p0.exponent - acc.exponent;
        add_exp = prod_p0.exponent;
        a_al    = (diff >= 5'd18) ? '0 : (acc.mantissa >> diff);
        b_al    = prod_p0.mantissa;
      end
      if (acc.sign == prod_p0.sign) begin
        add_mant = {1'b0, a_al} + {1'b0, b_al};
        add_sign = acc.sign;
      end else if (a_al >= b_al) begin
        add_mant = {1'b0, a_al - b_al};
        add_sign = acc.sign;
      end else begin
        add_mant = {1'b0, b_al - a_al};
        add_sign = prod_p0.sign;
      end
    end
  end

  mau_lzc u_lzc (
    .din   (sum_mant_p1),
    .count (lz)
  );

  // Normalise to bit 17 set, truncating; saturate on overflow, flush on underflow.
  always_comb begin
    logic signed [6:0] exp_n;
    logic [4:0]        sh;
    logic [MANT_W:0]   shl;
    norm  = '0;
    exp_n = '0;
    sh    = lz - 5'd1;
    shl   = sum_mant_p1 << sh;
    if (sum_mant_p1 != '0) begin
      norm.sign = sum_sign_p1;
      if (sum_mant_p1[MANT_W]) begin
        norm.mantissa = sum_mant_p1[MANT_W:1];
        exp_n         = signed'({2'b00, sum_exp_p1}) + 7'sd1;
      end else begin
        norm.mantissa = shl[MANT_W-1:0];
        exp_n         = signed'({2'b00, sum_exp_p1}) - signed'({2'b00, sh});
      end
      if (exp_n > 7'(EXP_MAX)) begin
        norm.exponent = EXP_W'(EXP_MAX);
        norm.mantissa = '1;
      end else if (exp_n < 7'sd1) begin
        norm = '0;
      end else begin
        norm.exponent = exp_n[EXP_W-1:0];
      end
    end
  end

  // State, accumulator, count and the inter-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      acc         <= '0;
      count       <= '0;
      prod_p0     <= '0;
      last_p0     <= 1'b0;
      sum_mant_p1 <= '0;
      sum_exp_p1  <= '0;
      sum_sign_p1 <= 1'b0;
    end else begin
      state <= state_d;
      armed <= 1'b1;
      // Stage 0: capture the accepted product.
      if (accept) begin
        prod_p0 <= '{sign: in_sign, exponent: in_exponent, mantissa: in_mantissa};
        last_p0 <= in_last;
        if (count != '1) count <= count + 1'b1;
      end
      // Stage 1: aligned sum.
      if (state == ST_ADD) begin
        sum_mant_p1 <= add_mant;
        sum_exp_p1  <= add_exp;
        sum_sign_p1 <= add_sign;
      end
      // Stage 2: normalised result into the accumulator.
      if (state == ST_NORM) acc <= norm;
      if (state == ST_DONE && out_ready) begin
        acc   <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mau_accumulator.sv
// Scoreboard bench for mau_accumulator: driver queues expected sums, monitor checks results.
module tb_mau_accumulator;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [17:0]      m;
    logic [4:0]       e;
    logic             s;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [17:0]      in_mantissa = '0;
  logic [4:0]       in_exponent = '0;
  logic             in_sign = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [17:0]      out_mantissa;
  logic [4:0]       out_exponent;
  logic             out_sign;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  exp_t sb[$];

  mau_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mantissa(in_mantissa), .in_exponent(in_exponent), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exponent(out_exponent), .out_sign(out_sign),
    .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_res(input logic [17:0] m, input logic [4:0] e, input logic s,
                            input logic [CNT_W-1:0] c);
    sb.push_back('{m: m, e: e, s: s, c: c});
  endtask

  // Present one product and hold it until the handshake edge.
  task automatic send(input logic [17:0] m, input logic [4:0] e, input logic s, input logic last);
    int n;
    in_valid = 1'b1; in_mantissa = m; in_exponent = e; in_sign = s; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin n++; @(posedge clk); end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: note last-product accepts, compare each presented result once.
  logic seen = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (in_valid && in_ready && in_last) last_acc_cyc = cyc;
    if (!rst_n) seen = 1'b0;
    else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        x = sb.pop_front();
        check("mantissa", out_mantissa, x.m);
        check("exponent", out_exponent, x.e);
        check("sign", out_sign, x.s);
        check("count", out_count, x.c);
        check("latency", cyc - last_acc_cyc, 3);
      end
    end
    if (out_valid && out_ready) seen = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t hold;
    #12;
    // Reset state while rst_n is held low.
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mantissa", out_mantissa, 0);
    check("rst_count", out_count, 0);
    @(negedge clk); rst_n = 1'b1;
    check("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", in_ready, 1);

    // 1.0 + 1.0 = 2.0
    expect_res(18'h20000, 5'd16, 1'b0, 2);
    send(18'h20000, 5'd15, 1'b0, 1'b0);
    send(18'h20000, 5'd15, 1'b0, 1'b1);
    drain();

    // 1.0 - 1.0 cancels exactly
    expect_res(18'h0, 5'd0, 1'b0, 2);
    send(18'h20000, 5'd15, 1'b0, 1'b0);
    send(18'h20000, 5'd15, 1'b1, 1'b1);
    drain();

    // 1.0 + zero product + 2^-14
    expect_res(18'h20008, 5'd15, 1'b0, 3);
    send(18'h20000, 5'd15, 1'b0, 1'b0);
    send(18'h20000, 5'd0,  1'b0, 1'b0);
    send(18'h20000, 5'd1,  1'b0, 1'b1);
    drain();

    // max + max saturates
    expect_res(18'h3FFFF, 5'd31, 1'b0, 2);
    send(18'h3FFFF, 5'd31, 1'b0, 1'b0);
    send(18'h3FFFF, 5'd31, 1'b0, 1'b1);
    drain();

    // -1.0 + 0.5 = -0.5 (left normalisation)
    expect_res(18'h20000, 5'd14, 1'b1, 2);
    send(18'h20000, 5'd15, 1'b1, 1'b0);
    send(18'h20000, 5'd14, 1'b0, 1'b1);
    drain();

    // Result below the smallest exponent flushes to zero
    expect_res(18'h0, 5'd0, 1'b0, 2);
    send(18'h30000, 5'd1, 1'b0, 1'b0);
    send(18'h20000, 5'd1, 1'b1, 1'b1);
    drain();

    // Product count saturates at all-ones
    expect_res(18'h0, 5'd0, 1'b0, 8'hFF);
    for (int i = 0; i < 259; i++) send(18'h0, 5'd0, 1'b0, 1'b0);
    send(18'h0, 5'd0, 1'b0, 1'b1);
    drain();

    // Consumer stall: outputs hold, no new products accepted
    out_ready = 1'b0;
    expect_res(18'h20000, 5'd15, 1'b0, 1);
    send(18'h20000, 5'd15, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin n++; @(negedge clk); end
      check("stall_reach_done", out_valid, 1);
    end
    hold = '{m: out_mantissa, e: out_exponent, s: out_sign, c: out_count};
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", {out_mantissa, out_exponent, out_sign, out_count},
            {18'h20000, 5'd15, 1'b0, 8'd1});
      @(negedge clk);
    end
    check("stall_stable", {out_mantissa, out_exponent, out_sign, out_count}, hold);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_cleared", {out_mantissa, out_exponent, out_sign, out_count}, 0);

    // Reset during NORM of the last product discards the partial sum
    send(18'h20000, 5'd15, 1'b0, 1'b0);
    in_valid = 1'b1; in_mantissa = 18'h20000; in_exponent = 5'd15; in_sign = 1'b0; in_last = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin n++; @(negedge clk); end
    end
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_count", out_count, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_outputs", {out_mantissa, out_exponent, out_sign, out_count}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", in_ready, 1);
    expect_res(18'h20000, 5'd16, 1'b0, 1);
    send(18'h20000, 5'd16, 1'b0, 1'b1);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mau_accumulator.md
MAU_ACCUMULATOR -- requirements
Module: mau_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the product counter.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product present.
- in_ready  out  1  block accepts product.
- in_last  in  1  final product of the current dot product.
- in_mantissa  in  18  product mantissa, unsigned.
- in_exponent  in  5  product exponent.
- in_sign  in  1  product sign, 1 = negative.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_mantissa  out  18  sum mantissa.
- out_exponent  out  5  sum exponent.
- out_sign  out  1  sum sign.
- out_count  out  CNT_W  products summed, saturating at all-ones.

Function
REQ-003 SHALL interpret operands as value = (-1)^s x m x 2^(e-32); e=0 or m=0 means zero.
REQ-004 SHALL run FSM IDLE -> ADD -> NORM -> IDLE, or NORM -> DONE when the accepted product had in_last=1.
REQ-005 SHALL assert in_ready only in IDLE; a product is accepted on in_valid && in_ready.
REQ-006 ADD SHALL right-shift the smaller-exponent magnitude by the exponent difference, with differences >= 18 contributing zero, then add or subtract sign-magnitude into a 19-bit result.
REQ-007 NORM SHALL normalize so mantissa bit 17 = 1:
- on carry: shift right 1, exponent +1;
- otherwise: shift left by the leading-zero count, exponent reduced by it;
- rounding: truncation toward zero.
REQ-008 Normalized exponent > 31 SHALL saturate to e=31, m=0x3FFFF, sign kept.
REQ-009 Normalized exponent < 1 SHALL flush to e=0, m=0, s=0.
REQ-010 Exact cancellation SHALL produce e=0, m=0, s=0.
REQ-011 A zero product SHALL be accepted and counted, leaving the accumulator unchanged.
REQ-012 DONE SHALL hold out_valid=1 and all out_* stable until out_ready=1, then clear the accumulator and count and return to IDLE on the same edge.
REQ-013 Latency SHALL be 3 cycles from accepting the in_last product to out_valid; throughput is one product per 3 cycles.
REQ-014 out_count SHALL increment per accepted product and saturate at 2^CNT_W-1.
REQ-015 out_mantissa, out_exponent, out_sign and out_count SHALL drive the accumulator registers directly.

Reset
REQ-016 rst_n low SHALL, asynchronously:
- force state IDLE;
- clear accumulator and count, so out_mantissa=0, out_exponent=0, out_sign=0, out_count=0;
- drive out_valid=0 and in_ready=0.
REQ-017 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-018 Reset in any state, including mid-ADD/NORM or DONE, SHALL discard the partial sum with no output handshake.

Structure
REQ-019 mau_pkg SHALL hold the FSM state enum, MANT_W=18, EXP_W=5, EXP_MAX=31, and a packed struct {sign, exponent, mantissa} shared with the multiplier stage.
REQ-020 Leading-zero counting SHALL be one sub-module, mau_lzc (19-bit input, 5-bit count).

Verification
REQ-021 The bench SHALL cover:
- 1.0 (m=0x20000,e=15,s=0) then 1.0 with last -> out m=0x20000, e=16, s=0, count=2, out_valid 3 cycles after the last accept.
- 1.0 then -1.0 with last -> m=0, e=0, s=0, count=2.
- 1.0 then (m=0x20000, e=1) with last -> m=0x20008, e=15; then (m=0x20000, e=0) -> contributes zero.
- (m=0x3FFFF, e=31) twice with last -> m=0x3FFFF, e=31 saturated.
- out_ready held low for 10 cycles in DONE -> outputs stable and in_ready=0; release -> accumulator cleared, in_ready=1 next cycle.
- rst_n pulsed low during NORM -> all outputs 0 immediately; the next single 2.0 last product returns m=0x20000, e=16, count=1.
